// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-entry registered RV32I decode stage between fetch and dispatch queue
//
// Optional feature macro: DECODE_PERF_CNT_EN (adds perf_decoded / perf_stall counters)
//
// Ports:
//   clk, rst                  core clock, asynchronous active-high reset
//   flush                     drop the held instruction and refuse input this cycle
//   fetch_valid/ready         handshake for fetch_instr / fetch_pc
//   dq_full, dq_w_en          dispatch queue backpressure and write strobe
//   dec_*                     registered decode results presented to the queue
//   perf_decoded, perf_stall  accept and stall counters (DECODE_PERF_CNT_EN only)
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_instr,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_ready,
    input  logic            dq_full,
    output logic            dq_w_en,
    output logic [XLEN-1:0] dec_pc,
    output logic [6:0]      dec_opcode,
    output logic [4:0]      dec_rd,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [2:0]      dec_funct3,
    output logic [6:0]      dec_funct7,
    output logic [XLEN-1:0] dec_imm,
    output logic            dec_uses_rs1,
    output logic            dec_uses_rs2,
    output logic            dec_writes_rd,
    output logic            dec_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_stall
`endif
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic            out_valid;
    logic            accept;
    logic [XLEN-1:0] instr_q;

    logic [XLEN-1:0] nxt_imm;
    logic            nxt_uses_rs1;
    logic            nxt_uses_rs2;
    logic            nxt_writes_rd;
    logic            nxt_illegal;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            rd_nonzero;

    assign fetch_ready = !flush && (!out_valid || !dq_full);
    assign accept      = fetch_valid && fetch_ready;
    assign dq_w_en     = out_valid && !dq_full && !flush;

    // Raw fields come straight from the held word, so they are copied
    // verbatim even for illegal encodings and are zero after reset.
    assign dec_opcode = instr_q[6:0];
    assign dec_rd     = instr_q[11:7];
    assign dec_funct3 = instr_q[14:12];
    assign dec_rs1    = instr_q[19:15];
    assign dec_rs2    = instr_q[24:20];
    assign dec_funct7 = instr_q[31:25];

    assign imm_i = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
    assign imm_s = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
    assign imm_b = {{20{fetch_instr[31]}}, fetch_instr[7], fetch_instr[30:25],
                    fetch_instr[11:8], 1'b0};
    assign imm_u = {fetch_instr[31:12], 12'b0};
    assign imm_j = {{12{fetch_instr[31]}}, fetch_instr[19:12], fetch_instr[20],
                    fetch_instr[30:21], 1'b0};
    assign rd_nonzero = (fetch_instr[11:7] != 5'd0);

    always_comb begin
        nxt_imm       = '0;
        nxt_uses_rs1  = 1'b0;
        nxt_uses_rs2  = 1'b0;
        nxt_writes_rd = 1'b0;
        nxt_illegal   = 1'b0;
        if (fetch_instr[1:0] != 2'b11) begin
            nxt_illegal = 1'b1;
        end else begin
            case (fetch_instr[6:0])
                OPC_LUI, OPC_AUIPC: begin
                    nxt_imm       = imm_u;
                    nxt_writes_rd = rd_nonzero;
                end
                OPC_JAL: begin
                    nxt_imm       = imm_j;
                    nxt_writes_rd = rd_nonzero;
                end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                    nxt_imm       = imm_i;
                    nxt_uses_rs1  = 1'b1;
                    nxt_writes_rd = rd_nonzero;
                end
                OPC_BRANCH: begin
                    nxt_imm      = imm_b;
                    nxt_uses_rs1 = 1'b1;
                    nxt_uses_rs2 = 1'b1;
                end
                OPC_STORE: begin
                    nxt_imm      = imm_s;
                    nxt_uses_rs1 = 1'b1;
                    nxt_uses_rs2 = 1'b1;
                end
                OPC_OP: begin
                    nxt_uses_rs1  = 1'b1;
                    nxt_uses_rs2  = 1'b1;
                    nxt_writes_rd = rd_nonzero;
                end
                OPC_MISC_MEM, OPC_SYSTEM: begin
                    nxt_imm = imm_i;
                end
                default: begin
                    nxt_illegal = 1'b1;
                end
            endcase
        end
    end

    // Only out_valid changes on flush or drain; the fields are left as they
    // are so the queue sees stable data whenever out_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            instr_q       <= '0;
            dec_pc        <= '0;
            dec_imm       <= '0;
            dec_uses_rs1  <= 1'b0;
            dec_uses_rs2  <= 1'b0;
            dec_writes_rd <= 1'b0;
            dec_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            instr_q       <= fetch_instr;
            dec_pc        <= fetch_pc;
            dec_imm       <= nxt_imm;
            dec_uses_rs1  <= nxt_uses_rs1;
            dec_uses_rs2  <= nxt_uses_rs2;
            dec_writes_rd <= nxt_writes_rd;
            dec_illegal   <= nxt_illegal;
        end else if (dq_w_en) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // Counters deliberately ignore flush; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_decoded <= '0;
            perf_stall   <= '0;
        end else begin
            if (accept) begin
                perf_decoded <= perf_decoded + 32'd1;
            end
            if (out_valid && dq_full) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
